// File: rtl/proc_pkg.sv
// Shared encodings for the simple-processor control unit: opcodes, tick states,
// bus mux selects and ALU operations.
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [3:0] {
    T0 = 4'b0001,
    T1 = 4'b0010,
    T2 = 4'b0100,
    T3 = 4'b1000
  } tick_e;

  localparam logic [3:0] SEL_G   = 4'd8;
  localparam logic [3:0] SEL_DIN = 4'd9;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_SHL = 3'b011;
  localparam logic [2:0] ALU_SHR = 3'b100;

  // ALU instructions take the long T1-T2-T3 path; everything else ends in T1.
  function automatic logic is_alu_op(logic [2:0] op);
    return !(op == OP_MV || op == OP_MVI || op == OP_ILL);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the latched instruction and current tick into
// datapath controls. Enable/reset gating is applied by the caller.
module instr_decode
  import proc_pkg::*;
#(
  parameter int unsigned IR_W  = 9,
  parameter int unsigned SEL_W = 4
) (
  input  logic [IR_W-1:0]  ir,
  input  tick_e            tick,
  output logic [SEL_W-1:0] bus_sel,
  output logic [7:0]       r_in,
  output logic             a_in,
  output logic             g_in,
  output logic [2:0]       alu_op,
  output logic             done,
  output logic             illegal
);

  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;

  assign op = ir[IR_W-1 -: 3];
  assign rx = ir[5:3];
  assign ry = ir[2:0];

  always_comb begin
    bus_sel = '0;
    r_in    = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    alu_op  = ALU_ADD;
    done    = 1'b0;
    illegal = 1'b0;
    unique case (tick)
      T0: ;
      T1: begin
        unique case (op)
          OP_MV: begin
            bus_sel = SEL_W'(ry);
            r_in    = 8'b1 << rx;
            done    = 1'b1;
          end
          OP_MVI: begin
            bus_sel = SEL_W'(SEL_DIN);
            r_in    = 8'b1 << rx;
            done    = 1'b1;
          end
          OP_ILL: begin
            done    = 1'b1;
            illegal = 1'b1;
          end
          default: begin
            bus_sel = SEL_W'(rx);
            a_in    = 1'b1;
          end
        endcase
      end
      T2: begin
        bus_sel = SEL_W'(ry);
        g_in    = 1'b1;
        unique case (op)
          OP_SUB:  alu_op = ALU_SUB;
          OP_MUL:  alu_op = ALU_MUL;
          OP_SHL:  alu_op = ALU_SHL;
          OP_SHR:  alu_op = ALU_SHR;
          default: alu_op = ALU_ADD;
        endcase
      end
      T3: begin
        bus_sel = SEL_W'(SEL_G);
        r_in    = 8'b1 << rx;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle sequencer for the 16-bit simple processor: latches the instruction,
// steps the one-hot tick T0-T3 and drives mux select, register enables and ALU op.
module proc_control_unit
  import proc_pkg::*;
#(
  parameter int unsigned IR_W  = 9,
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             run,
  input  logic [IR_W-1:0]  din,
  output logic [SEL_W-1:0] bus_sel,
  output logic [7:0]       r_in,
  output logic             a_in,
  output logic             g_in,
  output logic [2:0]       alu_op,
  output logic [3:0]       tick,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  tick_e            state_q, state_d;
  logic [IR_W-1:0]  ir_q, ir_d;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    if (enable) begin
      unique case (state_q)
        T0: begin
          if (run) begin
            state_d = T1;
            ir_d    = din;
          end
        end
        T1:      state_d = is_alu_op(ir_q[IR_W-1 -: 3]) ? T2 : T0;
        T2:      state_d = T3;
        T3:      state_d = T0;
        default: state_d = T0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  logic [SEL_W-1:0] dec_sel;
  logic [7:0]       dec_r_in;
  logic             dec_a_in;
  logic             dec_g_in;
  logic [2:0]       dec_alu_op;
  logic             dec_done;
  logic             dec_illegal;

  instr_decode #(
    .IR_W  (IR_W),
    .SEL_W (SEL_W)
  ) u_decode (
    .ir      (ir_q),
    .tick    (state_q),
    .bus_sel (dec_sel),
    .r_in    (dec_r_in),
    .a_in    (dec_a_in),
    .g_in    (dec_g_in),
    .alu_op  (dec_alu_op),
    .done    (dec_done),
    .illegal (dec_illegal)
  );

  // Write enables and pulses stall with enable; rst blanks everything without
  // waiting for the state register to settle.
  logic pulse_ok;
  assign pulse_ok = enable & ~rst;

  assign tick    = rst ? T0 : state_q;
  assign busy    = ~rst & (state_q != T0);
  assign bus_sel = rst ? '0 : dec_sel;
  assign alu_op  = rst ? ALU_ADD : dec_alu_op;
  assign r_in    = pulse_ok ? dec_r_in : '0;
  assign a_in    = pulse_ok & dec_a_in;
  assign g_in    = pulse_ok & dec_g_in;
  assign done    = pulse_ok & dec_done;
  assign illegal = pulse_ok & dec_illegal;

endmodule

// File: tb/tb_proc_control_unit.sv
// Bench for proc_control_unit: a datapath model driven by the DUT's controls
// is scored against an architectural register-file reference.
module tb_proc_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       run;
  logic [8:0] din;
  logic [3:0] bus_sel;
  logic [7:0] r_in;
  logic       a_in;
  logic       g_in;
  logic [2:0] alu_op;
  logic [3:0] tick;
  logic       busy;
  logic       done;
  logic       illegal;

  proc_control_unit #(.IR_W(9), .SEL_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .run     (run),
    .din     (din),
    .bus_sel (bus_sel),
    .r_in    (r_in),
    .a_in    (a_in),
    .g_in    (g_in),
    .alu_op  (alu_op),
    .tick    (tick),
    .busy    (busy),
    .done    (done),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ill;
    logic [2:0]  rx;
    logic [15:0] val;
    int          cycles;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] arch[8];
  logic [15:0] arch_save[8];
  logic [15:0] dp_r[8];
  logic [15:0] dp_a;
  logic [15:0] dp_g;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  // Architectural reference: what the instruction does to the register file.
  function automatic void push(input logic [8:0] ins, input logic [8:0] imm);
    exp_t        e;
    logic [2:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    op       = ins[8:6];
    e.rx     = ins[5:3];
    x        = arch[ins[5:3]];
    y        = arch[ins[2:0]];
    e.ill    = (op == 3'd7);
    e.cycles = (op == 3'd0 || op == 3'd1 || op == 3'd7) ? 1 : 3;
    case (op)
      3'd0:    e.val = y;
      3'd1:    e.val = {{7{imm[8]}}, imm};
      3'd2:    e.val = x + y;
      3'd3:    e.val = x - y;
      3'd4:    e.val = x * y;
      3'd5:    e.val = {y[14:0], 1'b0};
      3'd6:    e.val = {1'b0, y[15:1]};
      default: e.val = 16'h0;
    endcase
    if (!e.ill) arch[e.rx] = e.val;
    sb_q.push_back(e);
  endfunction

  function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b,
                                      input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return b << 1;
      3'd4:    return b >> 1;
      default: return 16'hbeef;
    endcase
  endfunction

  // Monitor: runs the datapath from the DUT's controls and scores each done.
  always @(negedge clk) begin
    logic [15:0] bus;
    logic [15:0] got_val;
    logic [32:0] got_v;
    logic [32:0] exp_v;
    exp_t        e;
    bit          ok;
    if (rst) begin
      cyc = 0;
    end else begin
      if (bus_sel < 4'd8)       bus = dp_r[bus_sel[2:0]];
      else if (bus_sel == 4'd8) bus = dp_g;
      else if (bus_sel == 4'd9) bus = {{7{din[8]}}, din};
      else                      bus = 16'hdead;
      ok = $onehot0({r_in, a_in, g_in}) && (tick == 4'b0100 || alu_op == 3'd0) &&
           (!illegal || done) && (busy == (tick != 4'b0001));
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL invariant t=%0t: got tick=%b r_in=%b a=%b g=%b alu=%b d=%b ill=%b busy=%b",
                 $time, tick, r_in, a_in, g_in, alu_op, done, illegal, busy);
      end
      if (enable && busy) cyc++;
      got_val = (r_in != 8'h0) ? bus : 16'h0;
      if (done) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow t=%0t: got done=1, required no pending instruction", $time);
        end else begin
          e = sb_q.pop_front();
          exp_v = {e.ill, e.ill ? 8'h0 : (8'h1 << e.rx), e.ill ? 16'h0 : e.val, 8'(e.cycles)};
          got_v = {illegal, r_in, got_val, 8'(cyc)};
          if (got_v !== exp_v) begin
            bad++;
            $display("FAIL retire t=%0t: got ill/r_in/val/cyc=%h, required %h",
                     $time, got_v, exp_v);
          end
        end
        cyc = 0;
      end
      if (g_in) dp_g = alu(dp_a, bus, alu_op);
      if (a_in) dp_a = bus;
      for (int i = 0; i < 8; i++) if (r_in[i]) dp_r[i] = bus;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] t, input logic [3:0] s,
                     input logic [7:0] r, input logic a, input logic g, input logic [2:0] al,
                     input logic d, input logic i, input logic b);
    logic [23:0] got_v;
    logic [23:0] exp_v;
    #1;
    exp_v = {t, s, r, a, g, al, d, i, b};
    got_v = {tick, bus_sel, r_in, a_in, g_in, alu_op, done, illegal, busy};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got tick/sel/r/a/g/alu/d/ill/busy=%h, required %h", name, got_v, exp_v);
    end
  endtask

  task automatic exec(input logic [8:0] ins, input logic [8:0] imm);
    int guard = 0;
    din    = ins;
    run    = 1'b1;
    enable = 1'b1;
    push(ins, imm);
    step();
    din = imm;
    do begin
      enable = ($urandom_range(0, 3) != 0);
      run    = 1'($urandom_range(0, 1));
      step();
      guard++;
    end while (tick != 4'b0001 && guard < 60);
    run    = 1'b0;
    enable = 1'b1;
    total++;
    if (tick != 4'b0001) begin
      bad++;
      $display("FAIL timeout: got tick=%b after %0d cycles, required 0001", tick, guard);
    end
  endtask

  initial begin
    rst    = 1'b0;
    enable = 1'b0;
    run    = 1'b0;
    din    = '0;
    #1 rst = 1'b1;
    chk("reset_state", 4'b0001, 4'd0, 8'h00, 0, 0, 3'd0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      arch[i] = 16'($urandom);
      dp_r[i] = arch[i];
    end
    dp_a = '0;
    dp_g = '0;
    step();
    rst    = 1'b0;
    enable = 1'b1;

    // mv R3 <- R5
    din = 9'b000_011_101; run = 1'b1; push(din, 9'h0); step();
    din = 9'h0AA; run = 1'b0;
    chk("mv_t1", 4'b0010, 4'd5, 8'h08, 0, 0, 3'd0, 1, 0, 1);
    step();
    chk("mv_back_t0", 4'b0001, 4'd0, 8'h00, 0, 0, 3'd0, 0, 0, 0);

    // mvi R7 <- sext(0x1C5)
    din = 9'b001_111_000; run = 1'b1; push(din, 9'h1C5); step();
    din = 9'h1C5; run = 1'b0;
    chk("mvi_t1", 4'b0010, 4'd9, 8'h80, 0, 0, 3'd0, 1, 0, 1);
    step();

    // sub R1, R2
    din = 9'b011_001_010; run = 1'b1; push(din, 9'h0); step();
    run = 1'b0;
    chk("sub_t1", 4'b0010, 4'd1, 8'h00, 1, 0, 3'd0, 0, 0, 1);
    step();
    chk("sub_t2", 4'b0100, 4'd2, 8'h00, 0, 1, 3'd1, 0, 0, 1);
    step();
    chk("sub_t3", 4'b1000, 4'd8, 8'h02, 0, 0, 3'd0, 1, 0, 1);
    step();

    // add R4, R6 with a 3-cycle stall in T2
    din = 9'b010_100_110; run = 1'b1; push(din, 9'h0); step();
    run = 1'b0; step();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_t2", 4'b0100, 4'd6, 8'h00, 0, 0, 3'd0, 0, 0, 1);
      step();
    end
    enable = 1'b1;
    chk("stall_release", 4'b0100, 4'd6, 8'h00, 0, 1, 3'd0, 0, 0, 1);
    step();
    chk("stall_t3", 4'b1000, 4'd8, 8'h10, 0, 0, 3'd0, 1, 0, 1);
    step();

    // illegal, then shr R2, R4 back-to-back with run held high
    din = 9'b111_000_000; run = 1'b1; push(din, 9'h0); step();
    din = 9'b110_010_100; push(din, 9'h0);
    chk("ill_t1", 4'b0010, 4'd0, 8'h00, 0, 0, 3'd0, 1, 1, 1);
    step();
    chk("b2b_idle_t0", 4'b0001, 4'd0, 8'h00, 0, 0, 3'd0, 0, 0, 0);
    step();
    run = 1'b0;
    chk("shr_t1", 4'b0010, 4'd2, 8'h00, 1, 0, 3'd0, 0, 0, 1);
    step();
    chk("shr_t2", 4'b0100, 4'd4, 8'h00, 0, 1, 3'd4, 0, 0, 1);
    step();
    chk("shr_t3", 4'b1000, 4'd8, 8'h04, 0, 0, 3'd0, 1, 0, 1);
    step();

    // reset in T2 of add R0, R1 aborts in the same cycle
    arch_save = arch;
    din = 9'b010_000_001; run = 1'b1; push(din, 9'h0); step();
    run = 1'b0; step();
    chk("rst_pre", 4'b0100, 4'd1, 8'h00, 0, 1, 3'd0, 0, 0, 1);
    rst = 1'b1;
    chk("rst_abort", 4'b0001, 4'd0, 8'h00, 0, 0, 3'd0, 0, 0, 0);
    sb_q.delete();
    arch = arch_save;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_run0", 4'b0001, 4'd0, 8'h00, 0, 0, 3'd0, 0, 0, 0);
      step();
    end

    // randomized instruction stream with stalls and run noise while busy
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) step();
      exec(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
    end

    step();
    step();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
